// File: rtl/mdr_unit.sv
// Memory data register with a small read/write handshake engine.
// Holds one data word, loads it from the internal bus or from memory
// (with half/byte lane extraction and sign/zero extension), and presents
// replicated write data plus byte enables while a write is outstanding.
// A wait counter aborts a transaction that never sees mem_ready.
module mdr_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic [DATA_W-1:0]   BusMuxOut,
    input  logic                MDRin,
    input  logic                Read,
    input  logic                Write,
    input  logic [1:0]          Size,
    input  logic                Signed,
    input  logic [1:0]          AddrLo,
    input  logic [DATA_W-1:0]   Mdatain,
    input  logic                mem_ready,
    output logic [DATA_W-1:0]   BusMuxInMDR,
    output logic [DATA_W-1:0]   Mdataout,
    output logic [DATA_W/8-1:0] ByteEn,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Counter value at which the current waiting cycle is the last one allowed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic [DATA_W-1:0]   mdr_r, mdr_nx_s;
    logic [1:0]          size_r, size_nx_s;
    logic                sgn_r, sgn_nx_s;
    logic [1:0]          addr_r, addr_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
    logic                done_r, done_nx_s;
    logic                err_r, err_nx_s;
    logic                mem_rd_r, mem_wr_r, busy_r;
    logic                mem_rd_nx_s, mem_wr_nx_s, busy_nx_s;
    logic [NB-1:0]       byte_en_r, byte_en_nx_s;
    logic [DATA_W-1:0]   wdata_r, wdata_nx_s;

    // Pick the addressed half/byte out of a memory word and extend it to full width.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] d,
                                                       input logic [1:0]        sz,
                                                       input logic              sg,
                                                       input logic [1:0]        addr);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        sh = d;
        r  = d;
        case (sz)
            2'b01: begin
                sh = d >> {addr[1], 4'b0000};
                r  = {{(DATA_W-16){sg & sh[15]}}, sh[15:0]};
            end
            2'b10: begin
                sh = d >> {addr, 3'b000};
                r  = {{(DATA_W-8){sg & sh[7]}}, sh[7:0]};
            end
            default: begin
                sh = d;
                r  = d;
            end
        endcase
        return r;
    endfunction

    // Copy the low half/byte of the MDR into every lane so any lane can be written.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [DATA_W-1:0] m,
                                                      input logic [1:0]        sz);
        logic [DATA_W-1:0] r;
        case (sz)
            2'b01:   r = {(DATA_W/16){m[15:0]}};
            2'b10:   r = {(DATA_W/8){m[7:0]}};
            default: r = m;
        endcase
        return r;
    endfunction

    // Byte-lane enables for the addressed half/byte; a word touches every lane.
    function automatic logic [NB-1:0] store_enables(input logic [1:0] sz,
                                                    input logic [1:0] addr);
        logic [NB-1:0] r;
        case (sz)
            2'b01:   r = NB'(2'b11) << {addr[1], 1'b0};
            2'b10:   r = NB'(1'b1) << addr;
            default: r = {NB{1'b1}};
        endcase
        return r;
    endfunction

    // Transaction sequencing: next state, MDR update, attribute capture, wait counting.
    always_comb begin
        state_nx_s = state_r;
        mdr_nx_s   = mdr_r;
        size_nx_s  = size_r;
        sgn_nx_s   = sgn_r;
        addr_nx_s  = addr_r;
        cnt_nx_s   = cnt_r;
        done_nx_s  = 1'b0;
        err_nx_s   = err_r;
        case (state_r)
            IDLE: begin
                if (Read || Write) begin
                    // Read has priority; attributes are frozen for the whole transaction.
                    state_nx_s = Read ? RD_WAIT : WR_WAIT;
                    size_nx_s  = Size;
                    sgn_nx_s   = Signed;
                    addr_nx_s  = AddrLo;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    err_nx_s   = 1'b0;
                end else if (MDRin) begin
                    mdr_nx_s = BusMuxOut;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD_WAIT: begin
                // A completion on the final waiting cycle still wins over the timeout.
                if (mem_ready) begin
                    mdr_nx_s   = load_extract(Mdatain, size_r, sgn_r, addr_r);
                    state_nx_s = IDLE;
                    done_nx_s  = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = IDLE;
                    err_nx_s   = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    state_nx_s = IDLE;
                    done_nx_s  = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = IDLE;
                    err_nx_s   = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they can be registered.
    always_comb begin
        mem_rd_nx_s  = 1'b0;
        mem_wr_nx_s  = 1'b0;
        busy_nx_s    = 1'b0;
        byte_en_nx_s = {NB{1'b0}};
        wdata_nx_s   = {DATA_W{1'b0}};
        if (state_nx_s == WR_WAIT) begin
            mem_wr_nx_s  = 1'b1;
            busy_nx_s    = 1'b1;
            byte_en_nx_s = store_enables(size_nx_s, addr_nx_s);
            wdata_nx_s   = store_lanes(mdr_nx_s, size_nx_s);
        end else if (state_nx_s == RD_WAIT) begin
            mem_rd_nx_s = 1'b1;
            busy_nx_s   = 1'b1;
        end else begin
            busy_nx_s = 1'b0;
        end
    end

    // State and output registers; Clear forces everything to its idle value at once.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_r   <= IDLE;
            mdr_r     <= {DATA_W{1'b0}};
            size_r    <= 2'b00;
            sgn_r     <= 1'b0;
            addr_r    <= 2'b00;
            cnt_r     <= {CNT_W{1'b0}};
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            mem_rd_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            busy_r    <= 1'b0;
            byte_en_r <= {NB{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            mdr_r     <= mdr_nx_s;
            size_r    <= size_nx_s;
            sgn_r     <= sgn_nx_s;
            addr_r    <= addr_nx_s;
            cnt_r     <= cnt_nx_s;
            done_r    <= done_nx_s;
            err_r     <= err_nx_s;
            mem_rd_r  <= mem_rd_nx_s;
            mem_wr_r  <= mem_wr_nx_s;
            busy_r    <= busy_nx_s;
            byte_en_r <= byte_en_nx_s;
            wdata_r   <= wdata_nx_s;
        end
    end

    assign BusMuxInMDR = mdr_r;
    assign Mdataout    = wdata_r;
    assign ByteEn      = byte_en_r;
    assign mem_rd      = mem_rd_r;
    assign mem_wr      = mem_wr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed plus randomized bench for mdr_unit with a behavioural lane/extension model.
module tb_mdr_unit;

    localparam int TO = 15;

    logic        Clock;
    logic        Clear;
    logic [31:0] BusMuxOut;
    logic        MDRin;
    logic        Read;
    logic        Write;
    logic [1:0]  Size;
    logic        Signed;
    logic [1:0]  AddrLo;
    logic [31:0] Mdatain;
    logic        mem_ready;
    logic [31:0] BusMuxInMDR;
    logic [31:0] Mdataout;
    logic [3:0]  ByteEn;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    int tests;
    int fails;

    mdr_unit #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Clear(Clear), .BusMuxOut(BusMuxOut), .MDRin(MDRin),
        .Read(Read), .Write(Write), .Size(Size), .Signed(Signed), .AddrLo(AddrLo),
        .Mdatain(Mdatain), .mem_ready(mem_ready), .BusMuxInMDR(BusMuxInMDR),
        .Mdataout(Mdataout), .ByteEn(ByteEn), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .busy(busy), .done(done), .err(err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Expected loaded value: take the addressed bytes arithmetically and extend.
    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] ad);
        longint nbytes;
        longint off;
        longint v;
        if (sz == 2'd1) begin
            nbytes = 2; off = (longint'(ad) / 2) * 2;
        end else if (sz == 2'd2) begin
            nbytes = 1; off = longint'(ad);
        end else begin
            nbytes = 4; off = 0;
        end
        v = (longint'(d) >> (8 * off)) % (64'sd1 << (8 * nbytes));
        if (sg && nbytes < 4 && v >= (64'sd1 << (8 * nbytes - 1)))
            v = v - (64'sd1 << (8 * nbytes));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] m, input logic [1:0] sz);
        if (sz == 2'd1) return (m % 32'h0001_0000) * 32'h0001_0001;
        else if (sz == 2'd2) return (m % 32'h0000_0100) * 32'h0101_0101;
        else return m;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] ad);
        int r;
        if (sz == 2'd1) r = 3 << (2 * (int'(ad) / 2));
        else if (sz == 2'd2) r = 1 << int'(ad);
        else r = 15;
        return r[3:0];
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hard stop in case the design wedges the stimulus somewhere unexpected.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main directed sequence followed by randomized transactions.
    initial begin
        logic [31:0] model_mdr;
        int          cycles;
        int          op;
        int          lat;
        logic [1:0]  sz;
        logic        sg;
        logic [1:0]  ad;
        logic [31:0] data;

        tests = 0; fails = 0;
        Clear = 1'b1; BusMuxOut = 32'h0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
        Size = 2'b00; Signed = 1'b0; AddrLo = 2'b00; Mdatain = 32'h0; mem_ready = 1'b0;

        #2 Clear = 1'b0;
        #1;
        check("rst_mdr", BusMuxInMDR, 32'h0);
        check("rst_flags", {mem_rd, mem_wr, busy, done, err}, 32'h0);
        check("rst_wr", {ByteEn, Mdataout[27:0]}, 32'h0);
        tick();
        #4 Clear = 1'b1;
        tick();
        check("idle_busy", busy, 32'h0);

        // Direct load from the bus.
        MDRin = 1'b1; BusMuxOut = 32'hDEAD_BEEF; tick(); MDRin = 1'b0;
        check("load_mdr", BusMuxInMDR, 32'hDEAD_BEEF);
        check("load_busy", busy, 32'h0);

        // Signed byte read from lane 2, attributes changed after start.
        Read = 1'b1; Size = 2'b10; Signed = 1'b1; AddrLo = 2'd2; Mdatain = 32'h12F4_5678;
        tick();
        Read = 1'b0; Size = 2'b00; Signed = 1'b0; AddrLo = 2'd0;
        check("rd_start", {mem_rd, mem_wr, busy}, 32'h5);
        check("rd_hold_mdr", BusMuxInMDR, 32'hDEAD_BEEF);
        tick(); tick();
        check("rd_wait", mem_rd, 32'h1);
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        check("rd_mdr", BusMuxInMDR, 32'hFFFF_FFF4);
        check("rd_done", {done, busy, mem_rd}, 32'h4);
        tick();
        check("rd_done_pulse", done, 32'h0);

        // Half-word write to the upper half.
        MDRin = 1'b1; BusMuxOut = 32'h0000_ABCD; tick(); MDRin = 1'b0;
        Write = 1'b1; Size = 2'b01; AddrLo = 2'd2; tick(); Write = 1'b0;
        check("wr_data", Mdataout, 32'hABCD_ABCD);
        check("wr_be", ByteEn, 32'hC);
        check("wr_strobes", {mem_rd, mem_wr}, 32'h1);
        MDRin = 1'b1; BusMuxOut = 32'h1111_1111; Read = 1'b1; tick();
        MDRin = 1'b0; Read = 1'b0;
        check("busy_ignore_mdr", BusMuxInMDR, 32'h0000_ABCD);
        check("busy_ignore_rd", {mem_rd, mem_wr}, 32'h1);
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        check("wr_done", {done, mem_wr, busy}, 32'h4);
        check("wr_be_idle", ByteEn, 32'h0);
        check("wr_mdr", BusMuxInMDR, 32'h0000_ABCD);

        // Read that never completes.
        Read = 1'b1; Size = 2'b00; Mdatain = 32'hCAFE_F00D; tick(); Read = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40 && busy == 1'b1; i++) begin
            cycles++;
            tick();
        end
        check("to_cycles", cycles, TO);
        check("to_err_done", {err, done}, 32'h2);
        check("to_mdr", BusMuxInMDR, 32'h0000_ABCD);

        // mem_ready while idle changes nothing; err is sticky.
        mem_ready = 1'b1; Mdatain = 32'h5555_5555; tick(); tick(); mem_ready = 1'b0;
        check("idle_ready_mdr", BusMuxInMDR, 32'h0000_ABCD);
        check("idle_ready_flags", {err, done, busy}, 32'h4);

        // Completion exactly on the final allowed waiting cycle.
        Read = 1'b1; Size = 2'b01; Signed = 1'b1; AddrLo = 2'd3; Mdatain = 32'h8001_7FFE;
        tick(); Read = 1'b0;
        check("start_clears_err", {err, busy}, 32'h1);
        repeat (TO - 1) tick();
        check("edge_still_busy", busy, 32'h1);
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        check("edge_done_err", {done, err}, 32'h2);
        check("edge_mdr", BusMuxInMDR, 32'hFFFF_8001);

        // Read wins over Write; Clear aborts mid-read.
        Read = 1'b1; Write = 1'b1; Size = 2'b00; tick(); Read = 1'b0; Write = 1'b0;
        check("both_rd_wins", {mem_rd, mem_wr}, 32'h2);
        #2 Clear = 1'b0;
        #1;
        check("clr_mdr", BusMuxInMDR, 32'h0);
        check("clr_flags", {mem_rd, mem_wr, busy, done, err}, 32'h0);
        check("clr_wr", {ByteEn, Mdataout[27:0]}, 32'h0);
        Clear = 1'b1; Read = 1'b1; Mdatain = 32'h1357_2468; tick(); Read = 1'b0;
        check("post_clr_rd", mem_rd, 32'h1);
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        check("post_clr_done", done, 32'h1);
        check("post_clr_mdr", BusMuxInMDR, 32'h1357_2468);
        model_mdr = 32'h1357_2468;

        // Randomized loads, reads and writes with random memory latency.
        for (int it = 0; it < 40; it++) begin
            op   = int'($urandom_range(2, 0));
            sz   = 2'($urandom_range(3, 0));
            sg   = 1'($urandom_range(1, 0));
            ad   = 2'($urandom_range(3, 0));
            data = $urandom;
            lat  = int'($urandom_range(TO + 2, 0));
            if (op == 0) begin
                MDRin = 1'b1; BusMuxOut = data; tick(); MDRin = 1'b0;
                model_mdr = data;
                check("rnd_load", BusMuxInMDR, model_mdr);
            end else begin
                Read = (op == 1); Write = (op == 2);
                Size = sz; Signed = sg; AddrLo = ad; Mdatain = data;
                tick();
                Read = 1'b0; Write = 1'b0;
                Size = 2'($urandom); Signed = 1'($urandom); AddrLo = 2'($urandom);
                if (op == 2) begin
                    check("rnd_wdata", Mdataout, model_wdata(model_mdr, sz));
                    check("rnd_be", ByteEn, model_be(sz, ad));
                end else begin
                    check("rnd_rd", mem_rd, 32'h1);
                end
                for (int w = 0; w < TO; w++) begin
                    mem_ready = (w == lat);
                    tick();
                    if (w == lat) break;
                end
                mem_ready = 1'b0;
                if (lat < TO) begin
                    if (op == 1) model_mdr = model_load(data, sz, sg, ad);
                    check("rnd_flags_ok", {busy, done, err}, 32'h2);
                end else begin
                    check("rnd_flags_to", {busy, done, err}, 32'h1);
                end
                check("rnd_mdr", BusMuxInMDR, model_mdr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdr_unit.md
MDR_UNIT -- requirements
Module: mdr_unit

Interface
REQ-001 Parameter: DATA_W, default 32, SHALL set the data width (multiple of 8, min 16).
REQ-002 Parameter: TIMEOUT, default 15, SHALL set the maximum cycles spent waiting for mem_ready.
REQ-003 Clock  in  1  system clock; all state SHALL update on the rising edge.
REQ-004 Clear  in  1  reset, asynchronous, active-low.
REQ-005 BusMuxOut  in  DATA_W  internal bus value for direct load.
REQ-006 MDRin  in  1  direct-load enable from the bus.
REQ-007 Read  in  1  request a memory read transaction.
REQ-008 Write  in  1  request a memory write transaction.
REQ-009 Size  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-010 Signed  in  1  sign-extend half/byte loads when 1, zero-extend when 0.
REQ-011 AddrLo  in  2  byte offset selecting the lane for half/byte accesses.
REQ-012 Mdatain  in  DATA_W  memory read data.
REQ-013 mem_ready  in  1  memory completion strobe.
REQ-014 BusMuxInMDR  out  DATA_W  current MDR contents to the bus.
REQ-015 Mdataout  out  DATA_W  write data to memory.
REQ-016 ByteEn  out  DATA_W/8  write byte-lane enables.
REQ-017 mem_rd, mem_wr  out  1 each  memory request strobes.
REQ-018 busy, done, err  out  1 each  status.

Function
REQ-019 FSM states SHALL be IDLE, RD_WAIT, WR_WAIT; busy SHALL be 1 in any state other than IDLE.
REQ-020 In IDLE, with Read=1, the block SHALL enter RD_WAIT next edge; with Write=1 (Read=0), it SHALL enter WR_WAIT; Read SHALL win when both are asserted.
REQ-021 In IDLE, with MDRin=1 and Read=Write=0, the MDR SHALL load BusMuxOut on the next edge; MDRin together with Read/Write SHALL be ignored.
REQ-022 mem_rd SHALL be 1 exactly while in RD_WAIT, and mem_wr exactly while in WR_WAIT.
REQ-023 In RD_WAIT, with mem_ready=1, the MDR SHALL capture the lane-extracted, extended Mdatain; the FSM SHALL return to IDLE; done SHALL pulse for one cycle.
REQ-024 Lane extraction:
  - half SHALL use bits [16*AddrLo[1] +: 16];
  - byte SHALL use bits [8*AddrLo +: 8];
  - word SHALL ignore AddrLo.
REQ-025 In WR_WAIT:
  - Mdataout SHALL replicate the MDR low half/byte across all lanes (word: MDR as-is);
  - ByteEn SHALL mark only the addressed lanes (word: all ones);
  - mem_ready SHALL return the FSM to IDLE with a one-cycle done pulse.
REQ-026 Size, Signed and AddrLo SHALL be registered at transaction start and held for its duration.
REQ-027 A wait counter SHALL clear on entry to RD_WAIT or WR_WAIT and increment each waiting cycle.
REQ-028 If the wait counter reaches TIMEOUT with no mem_ready:
  - the FSM SHALL return to IDLE;
  - the MDR SHALL be unchanged;
  - err SHALL set, and done SHALL stay 0.
REQ-029 err SHALL stay set until the next transaction start.
REQ-030 Read, Write and MDRin SHALL be ignored while busy=1.
REQ-031 mem_ready in IDLE SHALL be ignored.
REQ-032 mem_ready on the same edge as the timeout SHALL count as success.
REQ-033 BusMuxInMDR SHALL reflect the MDR register continuously; it SHALL change only on a direct load or read completion.

Reset
REQ-034 Clear=0 SHALL immediately force:
  - MDR = 0, state IDLE, counter 0;
  - mem_rd, mem_wr, busy, done, err = 0;
  - ByteEn = 0, Mdataout = 0.
REQ-035 Clear asserted mid-transaction SHALL abort it with no MDR update; after Clear rises, the first edge SHALL accept a new request.

Verification
REQ-036 MDRin=1, BusMuxOut=0xDEADBEEF, idle -> BusMuxInMDR=0xDEADBEEF after 1 edge, busy stays 0.
REQ-037 Read, Size=10, Signed=1, AddrLo=2, Mdatain=0x12F45678, mem_ready after 3 cycles -> BusMuxInMDR=0xFFFFFFF4, done for 1 cycle.
REQ-038 MDR=0x0000ABCD, Write, Size=01, AddrLo=2 -> Mdataout=0xABCDABCD, ByteEn=1100, mem_wr until mem_ready.
REQ-039 Read with mem_ready never asserted, TIMEOUT=15 -> IDLE after 15 wait cycles, err=1, MDR unchanged, done=0.
REQ-040 Read and Write together, then Clear=0 in RD_WAIT -> RD_WAIT entered first; all outputs 0 immediately on Clear; a post-reset Read completes normally.
